// File: rtl/locker_param_if.sv
// Bundles the digit-entry inputs and status outputs of locker_param.
//   master : drives Code, Code_vld, Mode, Clear; observes the status outputs.
//   slave  : the lock itself; receives the entry signals, drives
//            Unlock, Err, alert, Set_done, fail_cnt and digits.
interface locker_param_if #(
    parameter int unsigned DIGIT_W   = 4,
    parameter int unsigned MAX_TRIES = 3
);
    localparam int unsigned FC_W = $clog2(MAX_TRIES + 1);

    logic [DIGIT_W-1:0] Code;
    logic               Code_vld;
    logic               Mode;
    logic               Clear;
    logic               Unlock;
    logic               Err;
    logic               alert;
    logic               Set_done;
    logic [FC_W-1:0]    fail_cnt;
    logic [6:0]         digits;

    modport master (
        output Code, Code_vld, Mode, Clear,
        input  Unlock, Err, alert, Set_done, fail_cnt, digits
    );

    modport slave (
        input  Code, Code_vld, Mode, Clear,
        output Unlock, Err, alert, Set_done, fail_cnt, digits
    );
endinterface

// File: rtl/locker_param.sv
// Parametrised serial code lock.
// Digits arrive one per Code_vld strobe. A full sequence of CODE_LEN digits
// is either validated against the writable user code and the fixed admin
// code (Mode=1 on the first digit) or stored as the new user code (Mode=0).
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-low reset
//   bus  locker_param_if.slave:
//          Code/Code_vld/Mode/Clear in; Unlock/Err/alert/Set_done/fail_cnt/
//          digits (7-seg {g..a} of remaining tries) out
module locker_param #(
    parameter int unsigned                 DIGIT_W          = 4,
    parameter int unsigned                 CODE_LEN         = 4,
    parameter int unsigned                 MAX_TRIES        = 3,
    parameter logic [CODE_LEN*DIGIT_W-1:0] USER_INIT        = 16'h0103,
    parameter logic [CODE_LEN*DIGIT_W-1:0] ADMIN_CODE       = 16'h0207,
    parameter int unsigned                 ENTRY_TIMEOUT    = 16,
    parameter bit                          SET_NEEDS_UNLOCK = 1'b1
) (
    input logic           CLK,
    input logic           RST,
    locker_param_if.slave bus
);
    localparam int unsigned CODE_W   = CODE_LEN * DIGIT_W;
    localparam int unsigned IDX_W    = $clog2(CODE_LEN + 1);
    localparam int unsigned FC_W     = $clog2(MAX_TRIES + 1);
    localparam int unsigned TMO_W    = (ENTRY_TIMEOUT > 0) ? $clog2(ENTRY_TIMEOUT + 1) : 1;
    localparam int unsigned TMO_LAST = (ENTRY_TIMEOUT > 0) ? ENTRY_TIMEOUT - 1 : 0;

    localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FailMax  = FC_W'(MAX_TRIES);
    localparam logic [TMO_W-1:0] TmoLast  = TMO_W'(TMO_LAST);

    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CODE_W-1:0] buf_q, buf_d;
    logic [CODE_W-1:0] user_q, user_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [FC_W-1:0]   fail_q, fail_d;
    logic              mode_q, mode_d;
    logic              auth_q, auth_d;
    logic              unlock_q, unlock_d;
    logic              err_q, err_d;
    logic              alert_q, alert_d;
    logic              set_done_q, set_done_d;

    logic [CODE_W-1:0] shifted;
    logic              seq_mode;
    logic              seq_auth;
    logic              user_hit;
    logic              admin_hit;
    logic [3:0]        remaining;
    logic [6:0]        seg;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            idx_q      <= '0;
            buf_q      <= '0;
            user_q     <= USER_INIT;
            tmo_q      <= '0;
            fail_q     <= '0;
            mode_q     <= 1'b0;
            auth_q     <= 1'b0;
            unlock_q   <= 1'b0;
            err_q      <= 1'b0;
            alert_q    <= 1'b0;
            set_done_q <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            buf_q      <= buf_d;
            user_q     <= user_d;
            tmo_q      <= tmo_d;
            fail_q     <= fail_d;
            mode_q     <= mode_d;
            auth_q     <= auth_d;
            unlock_q   <= unlock_d;
            err_q      <= err_d;
            alert_q    <= alert_d;
            set_done_q <= set_done_d;
        end
    end

    always_comb begin
        idx_d      = idx_q;
        buf_d      = buf_q;
        user_d     = user_q;
        tmo_d      = tmo_q;
        fail_d     = fail_q;
        mode_d     = mode_q;
        auth_d     = auth_q;
        unlock_d   = unlock_q;
        err_d      = err_q;
        alert_d    = alert_q;
        set_done_d = 1'b0;

        // New digit enters at the LSB end so the first digit ends up in the MSBs.
        shifted   = (buf_q << DIGIT_W) | CODE_W'(bus.Code);
        user_hit  = (shifted == user_q);
        admin_hit = (shifted == ADMIN_CODE);
        seq_mode  = mode_q;
        seq_auth  = auth_q;

        if (bus.Clear) begin
            idx_d = '0;
            buf_d = '0;
            tmo_d = '0;
        end else if (bus.Code_vld) begin
            tmo_d = '0;
            if (idx_q == '0) begin
                // Set-mode authorisation is judged on the state before the
                // first digit clears Unlock.
                seq_mode = bus.Mode;
                seq_auth = !alert_q && (unlock_q || !SET_NEEDS_UNLOCK);
                mode_d   = seq_mode;
                auth_d   = seq_auth;
                unlock_d = 1'b0;
                err_d    = 1'b0;
            end
            if (idx_q == IdxLast) begin
                idx_d = '0;
                buf_d = '0;
                if (seq_mode) begin
                    // In alert only the admin code is honoured.
                    if (admin_hit || (user_hit && !alert_q)) begin
                        unlock_d = 1'b1;
                        err_d    = 1'b0;
                        alert_d  = 1'b0;
                        fail_d   = '0;
                    end else begin
                        unlock_d = 1'b0;
                        err_d    = 1'b1;
                        if (!alert_q) begin
                            if (fail_q != FailMax) begin
                                fail_d = fail_q + 1'b1;
                            end
                            alert_d = (fail_d == FailMax);
                        end
                    end
                end else if (seq_auth) begin
                    user_d     = shifted;
                    set_done_d = 1'b1;
                    unlock_d   = 1'b0;
                    err_d      = 1'b0;
                end else begin
                    unlock_d = 1'b0;
                    err_d    = 1'b1;
                end
            end else begin
                idx_d = idx_q + 1'b1;
                buf_d = shifted;
            end
        end else if ((ENTRY_TIMEOUT != 0) && (idx_q != '0)) begin
            if (tmo_q == TmoLast) begin
                idx_d = '0;
                buf_d = '0;
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        remaining = alert_q ? 4'd0 : (4'(MAX_TRIES) - 4'(fail_q));
        case (remaining)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = 7'h00;
        endcase
    end

    assign bus.Unlock   = unlock_q;
    assign bus.Err      = err_q;
    assign bus.alert    = alert_q;
    assign bus.Set_done = set_done_q;
    assign bus.fail_cnt = fail_q;
    assign bus.digits   = seg;
endmodule
